// File: rtl/mul_iter.sv
// Iterative radix-2^RADIX_BITS signed/unsigned multiplier producing a full 2*XLEN product.
// Optional `MUL_ZERO_SKIP_EN: a zero operand bypasses the EXEC phase and completes at once.
module mul_iter #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              flush,
    input  logic              signed1,
    input  logic [XLEN-1:0]   src1,
    input  logic              signed2,
    input  logic [XLEN-1:0]   src2,
    output logic [2*XLEN-1:0] out,
    output logic              okay,
    output logic              busy
);

    localparam int ITER  = XLEN / RADIX_BITS;
    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mult_q;
    logic [PW-1:0]   acc_q;
    logic            sgn_q;
    logic [PW-1:0]   out_q;
    logic            okay_q;

    logic            neg1, neg2;
    logic [XLEN-1:0] mag1_d, mag2_d;
    logic [PW-1:0]   digit_d;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   result_d;
    logic            zero_op;

    // Operands are reduced to magnitudes so the datapath is purely unsigned; the most-negative
    // value negates to 2^(XLEN-1), which still fits the unsigned XLEN-bit magnitude.
    always_comb begin
        neg1     = signed1 & src1[XLEN-1];
        neg2     = signed2 & src2[XLEN-1];
        mag1_d   = neg1 ? -src1 : src1;
        mag2_d   = neg2 ? -src2 : src2;
        digit_d  = PW'(mult_q[RADIX_BITS-1:0]);
        acc_d    = acc_q + mcand_q * digit_d;
        result_d = sgn_q ? -acc_q : acc_q;
    end

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (src1 == '0) || (src2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            out_q   <= '0;
            okay_q  <= 1'b0;
        end else begin
            okay_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trig && !flush) begin
                        mcand_q <= PW'(mag1_d);
                        mult_q  <= mag2_d;
                        sgn_q   <= neg1 ^ neg2;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= zero_op ? S_DONE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        // Shifting the multiplicand avoids a variable barrel shift per digit.
                        acc_q   <= acc_d;
                        mcand_q <= mcand_q << RADIX_BITS;
                        mult_q  <= mult_q >> RADIX_BITS;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        out_q  <= result_d;
                        okay_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out  = out_q;
    assign okay = okay_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: main instance at RADIX_BITS=2 plus 1/4/32 instances
// sharing the same stimulus for a radix sweep. Honours `MUL_ZERO_SKIP_EN when defined.
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        rst, trig, flush, signed1, signed2;
    logic [31:0] src1, src2;
    logic [63:0] out, out_r1, out_r4, out_r32;
    logic        okay, okay_r1, okay_r4, okay_r32;
    logic        busy, busy_r1, busy_r4, busy_r32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_iter #(.XLEN(32), .RADIX_BITS(2)) u_dut (
        .clk(clk), .rst(rst), .trig(trig), .flush(flush),
        .signed1(signed1), .src1(src1), .signed2(signed2), .src2(src2),
        .out(out), .okay(okay), .busy(busy)
    );
    mul_iter #(.XLEN(32), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst(rst), .trig(trig), .flush(flush),
        .signed1(signed1), .src1(src1), .signed2(signed2), .src2(src2),
        .out(out_r1), .okay(okay_r1), .busy(busy_r1)
    );
    mul_iter #(.XLEN(32), .RADIX_BITS(4)) u_r4 (
        .clk(clk), .rst(rst), .trig(trig), .flush(flush),
        .signed1(signed1), .src1(src1), .signed2(signed2), .src2(src2),
        .out(out_r4), .okay(okay_r4), .busy(busy_r4)
    );
    mul_iter #(.XLEN(32), .RADIX_BITS(32)) u_r32 (
        .clk(clk), .rst(rst), .trig(trig), .flush(flush),
        .signed1(signed1), .src1(src1), .signed2(signed2), .src2(src2),
        .out(out_r32), .okay(okay_r32), .busy(busy_r32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic s1, input logic [31:0] a, input logic s2, input logic [31:0] b);
        signed1 = s1; src1 = a; signed2 = s2; src2 = b;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_okay(output int lat);
        lat = 0;
        while (!okay && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; trig = 1'b0; flush = 1'b0;
        signed1 = 1'b0; signed2 = 1'b0; src1 = '0; src2 = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (out !== 64'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
        n_checks++; if (okay !== 1'b0) begin n_fail++; $display("FAIL reset_okay: got %b want 0", okay); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_unsigned();
        int lat;
        start(1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
        src1 = 32'h5555_5555; src2 = 32'h0000_0003;
        wait_okay(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL uu_latency: got %0d want 17", lat); end
        n_checks++; if (out !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL uu_out: got %h want fffffffe00000001", out); end
        tick();
        n_checks++; if (okay !== 1'b0) begin n_fail++; $display("FAIL uu_okay_pulse: got %b want 0", okay); end
    endtask

    task automatic test_signed();
        int lat;
        start(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000);
        wait_okay(lat);
        n_checks++; if (out !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL ss_minneg: got %h want 4000000000000000", out); end
        tick();
        start(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0002);
        wait_okay(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL su_latency: got %0d want 17", lat); end
        n_checks++; if (out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL su_out: got %h want fffffffffffffffe", out); end
        tick();
    endtask

    task automatic test_flush();
        int lat;
        int seen = 0;
        start(1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (okay) seen++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_exec_busy: got %b want 0", busy); end
        n_checks++; if (okay !== 1'b0 || seen != 0) begin n_fail++; $display("FAIL flush_exec_okay: got %b/%0d want 0/0", okay, seen); end
        n_checks++; if (out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL flush_exec_out: got %h want fffffffffffffffe", out); end
        start(1'b0, 32'h0000_1000, 1'b0, 32'h0000_0300);
        wait_okay(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL flush_restart_latency: got %0d want 17", lat); end
        n_checks++; if (out !== 64'h0000_0000_0030_0000) begin n_fail++; $display("FAIL flush_restart_out: got %h want 0000000000300000", out); end
        tick();
        // Abort in DONE: the op finished computing but must not publish.
        start(1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 16; i++) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_done_pre_busy: got %b want 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (okay !== 1'b0) begin n_fail++; $display("FAIL flush_done_okay: got %b want 0", okay); end
        n_checks++; if (out !== 64'h0000_0000_0030_0000) begin n_fail++; $display("FAIL flush_done_out: got %h want 0000000000300000", out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int okay_cnt = 0;
        start(1'b0, 32'h0000_0007, 1'b0, 32'h0000_0009);
        if (busy) busy_cnt++;
        for (int i = 1; i <= 17; i++) begin
            signed1 = i[0]; signed2 = i[1];
            src1 = 32'h0000_0100 + i; src2 = 32'hFFFF_0000 - i;
            trig = 1'b1;
            tick();
            if (busy) busy_cnt++;
            if (okay) okay_cnt++;
        end
        trig = 1'b0;
        n_checks++; if (out !== 64'h0000_0000_0000_003F) begin n_fail++; $display("FAIL b2b_out: got %h want 000000000000003f", out); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (okay) okay_cnt++;
        end
        n_checks++; if (busy_cnt != 17) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 17", busy_cnt); end
        n_checks++; if (okay_cnt != 1) begin n_fail++; $display("FAIL b2b_okay_pulses: got %0d want 1", okay_cnt); end
    endtask

    task automatic test_reset_mid();
        int okay_cnt = 0;
        start(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out !== 64'h0) begin n_fail++; $display("FAIL rstmid_out: got %h want 0", out); end
        n_checks++; if (okay !== 1'b0) begin n_fail++; $display("FAIL rstmid_okay: got %b want 0", okay); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        signed1 = 1'b0; src1 = 32'h0000_0005; signed2 = 1'b0; src2 = 32'h0000_0006;
        flush = 1'b1; trig = 1'b1;
        tick();
        flush = 1'b0; trig = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_trig_busy: got %b want 0", busy); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (okay) okay_cnt++;
        end
        n_checks++; if (okay_cnt != 0) begin n_fail++; $display("FAIL flush_trig_okay: got %0d pulses want 0", okay_cnt); end
    endtask

    task automatic test_zero_operand();
        int lat;
`ifdef MUL_ZERO_SKIP_EN
        int exp_zero_lat = 1;
`else
        int exp_zero_lat = 17;
`endif
        start(1'b0, 32'h0000_0000, 1'b0, 32'h1234_5678);
        wait_okay(lat);
        n_checks++; if (lat !== exp_zero_lat) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, exp_zero_lat); end
        n_checks++; if (out !== 64'h0) begin n_fail++; $display("FAIL zero_out: got %h want 0", out); end
        tick();
        start(1'b0, 32'h0000_0003, 1'b0, 32'h0000_0005);
        wait_okay(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL nonzero_latency: got %0d want 17", lat); end
        n_checks++; if (out !== 64'h0000_0000_0000_000F) begin n_fail++; $display("FAIL nonzero_out: got %h want 000000000000000f", out); end
        tick();
    endtask

    typedef struct {
        logic        s1;
        logic [31:0] a;
        logic        s2;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    task automatic test_radix_sweep();
        vec_t        vecs [6];
        int          exp_lat [4] = '{33, 17, 9, 2};
        int          got_lat [4];
        logic [63:0] got_out [4];
        logic [3:0]  oks;
        vecs[0] = '{1'b1, 32'hFFFF_FFFD, 1'b1, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1'b0, 32'h1234_5678, 1'b0, 32'h0000_0010, 64'h0000_0001_2345_6780};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        vecs[3] = '{1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[4] = '{1'b0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0000};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int v = 0; v < 6; v++) begin
            for (int d = 0; d < 4; d++) begin
                got_lat[d] = -1;
                got_out[d] = '0;
            end
            start(vecs[v].s1, vecs[v].a, vecs[v].s2, vecs[v].b);
            for (int t = 1; t <= 40; t++) begin
                tick();
                oks = {okay_r32, okay_r4, okay, okay_r1};
                if (oks[0] && got_lat[0] < 0) begin got_lat[0] = t; got_out[0] = out_r1;  end
                if (oks[1] && got_lat[1] < 0) begin got_lat[1] = t; got_out[1] = out;     end
                if (oks[2] && got_lat[2] < 0) begin got_lat[2] = t; got_out[2] = out_r4;  end
                if (oks[3] && got_lat[3] < 0) begin got_lat[3] = t; got_out[3] = out_r32; end
            end
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (got_lat[d] != exp_lat[d]) begin
                    n_fail++;
                    $display("FAIL sweep_latency vec%0d inst%0d: got %0d want %0d", v, d, got_lat[d], exp_lat[d]);
                end
                n_checks++;
                if (got_out[d] !== vecs[v].p) begin
                    n_fail++;
                    $display("FAIL sweep_out vec%0d inst%0d: got %h want %h", v, d, got_out[d], vecs[v].p);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_zero_operand();
        test_radix_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
